// File: rtl/axicb_pkg.sv
// Shared types for the AXI crossbar default (DECERR) slave.
// Response codes and FSM state encodings.
package axicb_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DRAIN,
        W_RESP
    } wr_fsm_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_fsm_t;

endpackage

// File: rtl/axicb_decerr_slv_if.sv
// AXI4 channel subset seen by the DECERR slave.
// WDATA/WSTRB/AxADDR are not carried: the slave never looks at them.
interface axicb_decerr_slv_if #(
    parameter int AXI_ID_W   = 8,
    parameter int AXI_DATA_W = 32
);
    import axicb_pkg::*;

    logic                  awvalid;
    logic                  awready;
    logic [AXI_ID_W-1:0]   awid;
    logic                  wvalid;
    logic                  wready;
    logic                  wlast;
    logic                  bvalid;
    logic                  bready;
    logic [AXI_ID_W-1:0]   bid;
    logic [1:0]            bresp;
    logic                  arvalid;
    logic                  arready;
    logic [AXI_ID_W-1:0]   arid;
    logic [7:0]            arlen;
    logic                  rvalid;
    logic                  rready;
    logic [AXI_ID_W-1:0]   rid;
    logic [1:0]            rresp;
    logic [AXI_DATA_W-1:0] rdata;
    logic                  rlast;

    modport master (
        output awvalid, awid, wvalid, wlast, bready,
        output arvalid, arid, arlen, rready,
        input  awready, wready, bvalid, bid, bresp,
        input  arready, rvalid, rid, rresp, rdata, rlast
    );

    modport slave (
        input  awvalid, awid, wvalid, wlast, bready,
        input  arvalid, arid, arlen, rready,
        output awready, wready, bvalid, bid, bresp,
        output arready, rvalid, rid, rresp, rdata, rlast
    );

endinterface

// File: rtl/axicb_scfifo.sv
// Single-clock register-file FIFO with registered full/empty flags.
// Push while full and pull while empty are ignored.
module axicb_scfifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pull,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   cnt;
    logic [ADDR_WIDTH:0]   cnt_nxt;
    logic                  do_push;
    logic                  do_pull;

    assign do_push  = push & ~full;
    assign do_pull  = pull & ~empty;
    assign data_out = mem[rd_ptr];

    always_comb begin
        cnt_nxt = cnt;
        if (do_push && !do_pull)
            cnt_nxt = cnt + 1'b1;
        else if (!do_push && do_pull)
            cnt_nxt = cnt - 1'b1;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pull)
                rd_ptr <= rd_ptr + 1'b1;
            cnt   <= cnt_nxt;
            full  <= (cnt_nxt == DEPTH_C);
            empty <= (cnt_nxt == '0);
        end
    end

    always_ff @(posedge aclk) begin
        if (do_push)
            mem[wr_ptr] <= data_in;
    end

endmodule

// File: rtl/axicb_decerr_slv.sv
// Default crossbar slave: answers every request with DECERR.
// Optional `AXICB_DECERR_RDATA_EN drives ERR_DATA on RDATA beats.
module axicb_decerr_slv
    import axicb_pkg::*;
#(
    parameter int                    AXI_ID_W    = 8,
    parameter int                    AXI_DATA_W  = 32,
    parameter int                    OSTDREQ_NUM = 4,
    parameter logic [AXI_DATA_W-1:0] ERR_DATA    = '0
) (
    input  logic              aclk,
    input  logic              aresetn,
    axicb_decerr_slv_if.slave bus
);
    localparam int AW   = $clog2(OSTDREQ_NUM);
    localparam int AR_W = AXI_ID_W + 8;

    wr_fsm_t             wr_state;
    wr_fsm_t             wr_nxt;
    logic [AXI_ID_W-1:0] aw_head;
    logic                aw_full;
    logic                aw_empty;
    logic                aw_pull;

    rd_fsm_t             rd_state;
    rd_fsm_t             rd_nxt;
    logic [AR_W-1:0]     ar_head;
    logic                ar_full;
    logic                ar_empty;
    logic                ar_pull;
    logic [7:0]          cnt;
    logic                r_act;
    logic                r_last;
    logic                r_hs;

    // Readys are masked in reset so nothing is accepted then.
    assign bus.awready = aresetn & ~aw_full;
    assign bus.arready = aresetn & ~ar_full;
    assign bus.bresp   = RESP_DECERR;
    assign bus.rresp   = RESP_DECERR;

    axicb_scfifo #(
        .DATA_WIDTH (AXI_ID_W),
        .ADDR_WIDTH (AW)
    ) u_aw_fifo (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .push     (bus.awvalid & bus.awready),
        .data_in  (bus.awid),
        .pull     (aw_pull),
        .data_out (aw_head),
        .full     (aw_full),
        .empty    (aw_empty)
    );

    always_ff @(posedge aclk) begin
        if (!aresetn)
            wr_state <= W_IDLE;
        else
            wr_state <= wr_nxt;
    end

    always_comb begin
        wr_nxt     = wr_state;
        aw_pull    = 1'b0;
        bus.wready = 1'b0;
        bus.bvalid = 1'b0;
        bus.bid    = '0;
        unique case (wr_state)
            W_IDLE: begin
                if (!aw_empty)
                    wr_nxt = W_DRAIN;
            end
            W_DRAIN: begin
                bus.wready = 1'b1;
                if (bus.wvalid && bus.wlast)
                    wr_nxt = W_RESP;
            end
            W_RESP: begin
                bus.bvalid = 1'b1;
                bus.bid    = aw_head;
                if (bus.bready) begin
                    aw_pull = 1'b1;
                    wr_nxt  = W_IDLE;
                end
            end
            default: wr_nxt = W_IDLE;
        endcase
    end

    axicb_scfifo #(
        .DATA_WIDTH (AR_W),
        .ADDR_WIDTH (AW)
    ) u_ar_fifo (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .push     (bus.arvalid & bus.arready),
        .data_in  ({bus.arlen, bus.arid}),
        .pull     (ar_pull),
        .data_out (ar_head),
        .full     (ar_full),
        .empty    (ar_empty)
    );

    assign r_act  = (rd_state == R_DATA);
    assign r_last = r_act & (cnt == ar_head[AXI_ID_W +: 8]);
    assign r_hs   = r_act & bus.rready;

    assign bus.rvalid = r_act;
    assign bus.rlast  = r_last;
    assign bus.rid    = r_act ? ar_head[AXI_ID_W-1:0] : '0;

`ifdef AXICB_DECERR_RDATA_EN
    assign bus.rdata = r_act ? ERR_DATA : '0;
`else
    logic unused_err_data;
    assign unused_err_data = ^ERR_DATA;
    assign bus.rdata       = '0;
`endif

    always_ff @(posedge aclk) begin
        if (!aresetn)
            rd_state <= R_IDLE;
        else
            rd_state <= rd_nxt;
    end

    // Counter stops on the last beat, so arlen=255 never wraps mid-burst.
    always_ff @(posedge aclk) begin
        if (!aresetn)
            cnt <= '0;
        else if (!r_act)
            cnt <= '0;
        else if (r_hs && !r_last)
            cnt <= cnt + 1'b1;
    end

    always_comb begin
        rd_nxt  = rd_state;
        ar_pull = 1'b0;
        unique case (rd_state)
            R_IDLE: begin
                if (!ar_empty)
                    rd_nxt = R_DATA;
            end
            R_DATA: begin
                if (r_hs && r_last) begin
                    ar_pull = 1'b1;
                    rd_nxt  = R_IDLE;
                end
            end
            default: rd_nxt = R_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axicb_decerr_slv.sv
// Scoreboard bench for axicb_decerr_slv.
// Build with +define+AXICB_DECERR_RDATA_EN to exercise ERR_DATA.
module tb_axicb_decerr_slv;
    import axicb_pkg::*;

`ifdef AXICB_DECERR_RDATA_EN
    localparam logic [31:0] EXP_RDATA = 32'hDEAD_BEEF;
`else
    localparam logic [31:0] EXP_RDATA = 32'h0;
`endif

    typedef struct {
        logic [7:0] id;
        logic       last;
    } rexp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   r_beats = 0;
    int   r_lasts = 0;

    rexp_t      rq[$];
    logic [7:0] bq[$];

    axicb_decerr_slv_if #(.AXI_ID_W(8), .AXI_DATA_W(32)) bus ();

    axicb_decerr_slv #(
        .AXI_ID_W    (8),
        .AXI_DATA_W  (32),
        .OSTDREQ_NUM (4),
        .ERR_DATA    (32'hDEAD_BEEF)
    ) dut (
        .aclk    (clk),
        .aresetn (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.rvalid && bus.rready) begin
            if (rq.size() == 0) begin
                chk("r_unexpected", 1, 0);
            end else begin
                rexp_t e;
                e = rq.pop_front();
                chk("rid", bus.rid, e.id);
                chk("rlast", bus.rlast, e.last);
                chk("rresp", bus.rresp, 2'b11);
                chk("rdata", bus.rdata, EXP_RDATA);
                r_beats++;
                if (bus.rlast)
                    r_lasts++;
            end
        end
        if (rst_n && bus.bvalid && bus.bready) begin
            if (bq.size() == 0) begin
                chk("b_unexpected", 1, 0);
            end else begin
                chk("bid", bus.bid, bq.pop_front());
                chk("bresp", bus.bresp, 2'b11);
            end
        end
    end

    task automatic send_ar(input logic [7:0] id, input logic [7:0] len);
        int n;
        bit hs;
        n  = 0;
        hs = 0;
        bus.arvalid = 1'b1;
        bus.arid    = id;
        bus.arlen   = len;
        while (!hs && n < 200) begin
            @(negedge clk);
            hs = bus.arready;
            @(posedge clk);
            #1;
            n++;
        end
        bus.arvalid = 1'b0;
        if (!hs) begin
            chk("ar_timeout", 0, 1);
        end else begin
            for (int i = 0; i <= int'(len); i++)
                rq.push_back('{id: id, last: (i == int'(len))});
        end
    endtask

    task automatic send_aw(input logic [7:0] id);
        int n;
        bit hs;
        n  = 0;
        hs = 0;
        bus.awvalid = 1'b1;
        bus.awid    = id;
        while (!hs && n < 200) begin
            @(negedge clk);
            hs = bus.awready;
            @(posedge clk);
            #1;
            n++;
        end
        bus.awvalid = 1'b0;
        if (!hs)
            chk("aw_timeout", 0, 1);
        else
            bq.push_back(id);
    endtask

    task automatic send_w(input int beats);
        for (int i = 0; i < beats; i++) begin
            int n;
            bit hs;
            n  = 0;
            hs = 0;
            bus.wvalid = 1'b1;
            bus.wlast  = (i == beats - 1);
            while (!hs && n < 200) begin
                @(negedge clk);
                hs = bus.wready;
                @(posedge clk);
                #1;
                n++;
            end
            if (!hs)
                chk("w_timeout", 0, 1);
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
    endtask

    task automatic wait_r_drain(input int budget, input bit rnd);
        int n;
        n = 0;
        while (rq.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            if (rnd)
                bus.rready = 1'($urandom_range(0, 1));
            n++;
        end
        chk("r_drain", rq.size(), 0);
        bus.rready = 1'b1;
    endtask

    task automatic wait_b_drain(input int budget);
        int n;
        n = 0;
        while (bq.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("b_drain", bq.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1);
    end

    initial begin
        bus.awvalid = 0; bus.awid = 0; bus.wvalid = 0; bus.wlast = 0;
        bus.bready  = 0; bus.arvalid = 0; bus.arid = 0; bus.arlen = 0;
        bus.rready  = 1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_arready", bus.arready, 0);
        chk("rst_awready", bus.awready, 0);
        chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_bresp", bus.bresp, 2'b11);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_arready", bus.arready, 1);
        chk("idle_awready", bus.awready, 1);
        chk("idle_wready", bus.wready, 0);
        chk("idle_bvalid", bus.bvalid, 0);
        chk("idle_rlast", bus.rlast, 0);
        chk("idle_rdata", bus.rdata, 0);
        chk("idle_rresp", bus.rresp, 2'b11);
        @(posedge clk);
        #1;

        // 4-beat read with latency check
        send_ar(8'h12, 8'd3);
        @(negedge clk);
        chk("ar_lat_n1", bus.rvalid, 0);
        @(negedge clk);
        chk("ar_lat_n2", bus.rvalid, 1);
        wait_r_drain(100, 0);
        @(negedge clk);
        chk("r_done_rdata", bus.rdata, 0);

        // write with stalled B
        @(posedge clk);
        #1;
        send_aw(8'h05);
        send_w(2);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("b_hold_valid", bus.bvalid, 1);
            chk("b_hold_id", bus.bid, 8'h05);
            @(posedge clk);
            #1;
        end
        bus.bready = 1'b1;
        wait_b_drain(50);
        @(negedge clk);
        chk("b_after", bus.bvalid, 0);

        // fill the AR FIFO with rready low
        @(posedge clk);
        #1;
        bus.rready = 1'b0;
        for (int i = 1; i <= 4; i++)
            send_ar(8'(i), 8'd0);
        @(negedge clk);
        chk("ar_full", bus.arready, 0);
        chk("r_stall_valid", bus.rvalid, 1);
        chk("r_stall_id", bus.rid, 8'h01);
        @(negedge clk);
        chk("r_stall_id2", bus.rid, 8'h01);
        @(posedge clk);
        #1;
        bus.rready = 1'b1;
        wait_r_drain(100, 0);

        // 256-beat burst under random backpressure
        r_beats = 0;
        r_lasts = 0;
        send_ar(8'h33, 8'd255);
        wait_r_drain(4000, 1);
        chk("long_beats", r_beats, 256);
        chk("long_lasts", r_lasts, 1);

        // concurrent read and write
        @(posedge clk);
        #1;
        fork
            send_ar(8'h21, 8'd2);
            begin
                send_aw(8'h0A);
                send_w(3);
            end
        join
        wait_r_drain(100, 0);
        wait_b_drain(100);

        // reset in the middle of a burst
        @(posedge clk);
        #1;
        r_beats = 0;
        send_ar(8'h44, 8'd7);
        for (int n = 0; n < 50 && r_beats < 2; n++)
            @(negedge clk);
        chk("rst_wait", r_beats, 2);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        rq.delete();
        @(negedge clk);
        chk("mid_rst_arready", bus.arready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_rvalid", bus.rvalid, 0);
        chk("post_rst_arready", bus.arready, 1);
        chk("post_rst_rid", bus.rid, 0);
        @(posedge clk);
        #1;
        r_lasts = 0;
        send_ar(8'h55, 8'd1);
        wait_r_drain(100, 0);
        chk("post_rst_lasts", r_lasts, 1);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
